alu_exec_ctrl: RTL and testbench
================================

// Module: alu_exec_ctrl
// PURPOSE
//  Execute-stage sequencer and register file; the stage directly upstream of the 8-bit ALU.
//  Accepts one 8-bit register-to-register instruction over a valid/ready handshake.
//  Reads two source registers, drives the ALU, captures its result and flags, and writes back the result.
//  Also provides an immediate-load port and a debug read port for the register file.
// PARAMETERS
//  DW    8  data width; fixed at 8 to match the ALU
//  RA_W  2  register address width; the file holds NREGS = 2**RA_W = 4 registers
// PORTS
//  clk          in   1     system clock; all state changes on the rising edge
//  rst_n        in   1     asynchronous reset, active low
//  instr_valid  in   1     instr holds a valid instruction
//  instr_ready  out  1     block can accept an instruction (high only in IDLE)
//  instr        in   8     [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2
//  ld_valid     in   1     immediate-load request
//  ld_ready     out  1     load can be accepted (high only in IDLE)
//  ld_addr      in   RA_W  destination register of the load
//  ld_data      in   DW    load value
//  alu_a        out  DW    ALU operand r0 (from rs1)
//  alu_b        out  DW    ALU operand r1 (from rs2)
//  alu_sel      out  2     ALU select: 00 ADD, 01 SUB, 10 AND, 11 OR
//  alu_result   in   DW    ALU r2
//  alu_ovf      in   1     ALU carry-out flag
//  alu_brw      in   1     ALU borrow flag
//  res_valid    out  1     one-cycle pulse during writeback
//  res_data     out  DW    written-back value; valid while res_valid is high
//  flag_c       out  1     carry flag register
//  flag_b       out  1     borrow flag register
//  flag_z       out  1     zero flag register
//  dbg_addr     in   RA_W  debug read address
//  dbg_data     out  DW    combinational read of regfile[dbg_addr]
// BEHAVIOUR
//  - Reset is asynchronous and overrides everything:
//    - state = IDLE; all registers and flags = 0; res_valid = 0; res_data = 0.
//    - alu_a, alu_b and alu_sel come from operand registers, which reset to 0.
//    - A reset mid-operation discards the in-flight instruction; no writeback occurs.
//  - State machine (2-bit state register):
//    - IDLE: instr_ready = ld_ready = 1. On instr_valid, latch opcode/rd/rs1/rs2 and go to READ.
//    - READ: op_a <= regfile[rs1], op_b <= regfile[rs2], sel <= opcode. Go to EXEC.
//    - EXEC: the ALU sees stable operands. Capture alu_result, alu_ovf and alu_brw into holding registers. Go to WB.
//    - WB: regfile[rd] <= result; flag_c <= ovf; flag_b <= brw; flag_z <= (result == 0); res_valid = 1. Go to IDLE.
//  - Timing: accept edge T. Writeback is visible in the regfile and flags after edge T+3.
//    The next instruction can be accepted at edge T+4, giving one instruction per 4 cycles.
//  - A load is accepted on ld_valid & ld_ready and writes regfile[ld_addr] at that edge.
//    - A load and an instruction in the same IDLE cycle are both accepted.
//    - That instruction's READ sees the loaded value.
//  - When busy, instr_valid and ld_valid are ignored. The requester must hold them until ready is seen.
//  - Arithmetic: result is 8 bits and wraps; the ALU drops the 9th bit except as ovf.
//    The ALU reports ovf = brw = 0 for AND/OR, so logic ops clear C and B.
//  - The flags change only in WB; a load does not affect the flags.
//  - A back-to-back hazard is impossible: the next READ follows the previous WB.
//  - Aliasing (rd, rs1 and rs2 may be equal) is legal.
// STRUCTURE
//  - cpu_pkg holds:
//    - opcode localparams OP_ADD/OP_SUB/OP_AND/OP_OR;
//    - state encodings S_IDLE/S_READ/S_EXEC/S_WB;
//    - instr field bit positions.
//  - One sub-module, reg_file:
//    - NREGS x DW registers with async reset;
//    - one synchronous write port, with WB and load muxed by the FSM;
//    - two combinational read ports plus the debug read port.
// TESTING
//  - Load r0=0xC8, r1=0x64; ADD rd=2 -> r2=0x2C, C=1, B=0, Z=0, res_valid one cycle at T+3.
//  - Load r0=0x05, r1=0x07; SUB rd=3 -> r3=0xFE, B=1, C=0, Z=0.
//  - Load r0=0xF0, r1=0x0F; AND rd=0 -> r0=0x00, Z=1, C=B=0. Then OR rd=1, rs1=rs2=1 -> r1 unchanged, Z=0.
//  - Hold instr_valid for 10 cycles with ADD r1=r1+r1, starting from r1=0x01:
//    - ready high every 4th cycle;
//    - after 2 accepts r1=0x04;
//    - no instruction is dropped or duplicated.
//  - Assert rst_n low during EXEC -> regs/flags 0, no res_valid, IDLE with instr_ready=1 on release.
//  - Same-cycle load r2=0x10 and instr ADD rd=3, rs1=2, rs2=2 -> r3=0x20.

Source files
------------

// File: rtl/alu_exec_ctrl_pkg.sv
// Shared constants for the execute-stage sequencer: widths, ALU opcodes,
// FSM state encodings and instruction field positions.
package alu_exec_ctrl_pkg;

    localparam int DW    = 8;
    localparam int RA_W  = 2;
    localparam int NREGS = 2 ** RA_W;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // instr = {opcode[7:6], rd[5:4], rs1[3:2], rs2[1:0]}
    localparam int OPC_LSB = 6;
    localparam int RD_LSB  = 4;
    localparam int RS1_LSB = 2;
    localparam int RS2_LSB = 0;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Bundle of the instruction/load handshakes, ALU bus, result/flag outputs
// and debug read port. slave = the sequencer, master = its environment.
interface alu_exec_ctrl_if;
    import alu_exec_ctrl_pkg::*;

    logic            instr_valid;
    logic            instr_ready;
    logic [7:0]      instr;
    logic            ld_valid;
    logic            ld_ready;
    logic [RA_W-1:0] ld_addr;
    logic [DW-1:0]   ld_data;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [1:0]      alu_sel;
    logic [DW-1:0]   alu_result;
    logic            alu_ovf;
    logic            alu_brw;
    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic            flag_c;
    logic            flag_b;
    logic            flag_z;
    logic [RA_W-1:0] dbg_addr;
    logic [DW-1:0]   dbg_data;

    modport slave (
        input  instr_valid, instr, ld_valid, ld_addr, ld_data,
               alu_result, alu_ovf, alu_brw, dbg_addr,
        output instr_ready, ld_ready, alu_a, alu_b, alu_sel,
               res_valid, res_data, flag_c, flag_b, flag_z, dbg_data
    );

    modport master (
        output instr_valid, instr, ld_valid, ld_addr, ld_data,
               alu_result, alu_ovf, alu_brw, dbg_addr,
        input  instr_ready, ld_ready, alu_a, alu_b, alu_sel,
               res_valid, res_data, flag_c, flag_b, flag_z, dbg_data
    );

endinterface

// File: rtl/alu_exec_ctrl_reg_file.sv
// NREGS x DW register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port.
module alu_exec_ctrl_reg_file
    import alu_exec_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [RA_W-1:0] i_waddr,
    input  logic [DW-1:0]   i_wdata,
    input  logic [RA_W-1:0] i_raddr1,
    input  logic [RA_W-1:0] i_raddr2,
    input  logic [RA_W-1:0] i_dbg_addr,
    output logic [DW-1:0]   o_rdata1,
    output logic [DW-1:0]   o_rdata2,
    output logic [DW-1:0]   o_dbg_data
);

    logic [NREGS-1:0][DW-1:0] r_regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_regs <= '0;
        else if (i_we)
            r_regs[i_waddr] <= i_wdata;
    end

    assign o_rdata1   = r_regs[i_raddr1];
    assign o_rdata2   = r_regs[i_raddr2];
    assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: IDLE -> READ -> EXEC -> WB, one instruction per
// four cycles, driving an external 8-bit ALU and writing its result back.
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_ctrl_if.slave bus
);

    state_t          r_state, w_next;
    logic [1:0]      r_op, r_sel;
    logic [RA_W-1:0] r_rd, r_rs1, r_rs2;
    logic [DW-1:0]   r_op_a, r_op_b, r_res;
    logic            r_ovf, r_brw;
    logic            r_fc, r_fb, r_fz;

    logic            w_idle, w_ld_acc, w_instr_acc, w_we;
    logic [RA_W-1:0] w_waddr;
    logic [DW-1:0]   w_wdata, w_rd1, w_rd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.instr_valid) w_next = S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Single write port: WB owns it in S_WB, loads can only land in S_IDLE.
    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_ld_acc    = w_idle && bus.ld_valid;
        w_instr_acc = w_idle && bus.instr_valid;
        w_we        = 1'b0;
        w_waddr     = bus.ld_addr;
        w_wdata     = bus.ld_data;
        if (r_state == S_WB) begin
            w_we    = 1'b1;
            w_waddr = r_rd;
            w_wdata = r_res;
        end else if (w_ld_acc) begin
            w_we    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_rd   <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_op_a <= '0;
            r_op_b <= '0;
            r_sel  <= '0;
            r_res  <= '0;
            r_ovf  <= 1'b0;
            r_brw  <= 1'b0;
            r_fc   <= 1'b0;
            r_fb   <= 1'b0;
            r_fz   <= 1'b0;
        end else begin
            if (w_instr_acc) begin
                r_op  <= bus.instr[OPC_LSB +: 2];
                r_rd  <= bus.instr[RD_LSB  +: RA_W];
                r_rs1 <= bus.instr[RS1_LSB +: RA_W];
                r_rs2 <= bus.instr[RS2_LSB +: RA_W];
            end
            if (r_state == S_READ) begin
                r_op_a <= w_rd1;
                r_op_b <= w_rd2;
                r_sel  <= r_op;
            end
            if (r_state == S_EXEC) begin
                r_res <= bus.alu_result;
                r_ovf <= bus.alu_ovf;
                r_brw <= bus.alu_brw;
            end
            if (r_state == S_WB) begin
                r_fc <= r_ovf;
                r_fb <= r_brw;
                r_fz <= (r_res == '0);
            end
        end
    end

    alu_exec_ctrl_reg_file u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_raddr1   (r_rs1),
        .i_raddr2   (r_rs2),
        .i_dbg_addr (bus.dbg_addr),
        .o_rdata1   (w_rd1),
        .o_rdata2   (w_rd2),
        .o_dbg_data (bus.dbg_data)
    );

    assign bus.instr_ready = w_idle;
    assign bus.ld_ready    = w_idle;
    assign bus.alu_a       = r_op_a;
    assign bus.alu_b       = r_op_b;
    assign bus.alu_sel     = r_sel;
    assign bus.res_valid   = (r_state == S_WB);
    assign bus.res_data    = r_res;
    assign bus.flag_c      = r_fc;
    assign bus.flag_b      = r_fb;
    assign bus.flag_z      = r_fz;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed + random bench for alu_exec_ctrl with a behavioural ALU and an
// array-based reference model of the register file and flags.
module tb_alu_exec_ctrl;
    import alu_exec_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_exec_ctrl_if bus ();

    alu_exec_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External ALU seen by the sequencer
    logic [8:0] alu_t;
    always_comb begin
        alu_t       = '0;
        bus.alu_ovf = 1'b0;
        bus.alu_brw = 1'b0;
        case (bus.alu_sel)
            2'b00:   begin alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}; bus.alu_ovf = alu_t[8]; end
            2'b01:   begin alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b}; bus.alu_brw = alu_t[8]; end
            2'b10:   alu_t = {1'b0, bus.alu_a & bus.alu_b};
            default: alu_t = {1'b0, bus.alu_a | bus.alu_b};
        endcase
        bus.alu_result = alu_t[7:0];
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] m_regs [4];
    logic m_c, m_b, m_z;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output logic bw);
        int s;
        c  = 1'b0;
        bw = 1'b0;
        case (op)
            OP_ADD: begin s = int'(a) + int'(b); c = (s > 255); r = 8'(s); end
            OP_SUB: begin s = int'(a) - int'(b); bw = (s < 0); r = 8'(s); end
            OP_AND: r = a & b;
            default: r = a | b;
        endcase
    endfunction

    task automatic chk_flags(input string tag);
        chk({tag, " C"}, 8'(bus.flag_c), 8'(m_c));
        chk({tag, " B"}, 8'(bus.flag_b), 8'(m_b));
        chk({tag, " Z"}, 8'(bus.flag_z), 8'(m_z));
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            bus.dbg_addr = 2'(i);
            #1;
            chk($sformatf("%s r%0d", tag, i), bus.dbg_data, m_regs[i]);
        end
    endtask

    task automatic do_load(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        chk("ld_ready", 8'(bus.ld_ready), 8'd1);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        m_regs[a] = d;
        chk_flags("load");
        chk_regs("load");
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input bit with_ld, input logic [1:0] la, input logic [7:0] ld);
        logic [7:0] a, b, r;
        logic c, bw;
        int w;
        @(negedge clk);
        bus.instr       = {op, rd, rs1, rs2};
        bus.instr_valid = 1'b1;
        if (with_ld) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = la;
            bus.ld_data  = ld;
        end
        w = 0;
        while (!bus.instr_ready && w < 20) begin @(negedge clk); w++; end
        chk({tag, " accept"}, 8'(w < 20), 8'd1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.ld_valid    = 1'b0;
        if (with_ld) m_regs[la] = ld;
        a = m_regs[rs1];
        b = m_regs[rs2];
        model(op, a, b, r, c, bw);
        chk({tag, " rv_read"}, 8'(bus.res_valid), 8'd0);
        chk({tag, " rdy_busy"}, 8'(bus.instr_ready), 8'd0);
        @(negedge clk);
        chk({tag, " alu_a"}, bus.alu_a, a);
        chk({tag, " alu_b"}, bus.alu_b, b);
        chk({tag, " alu_sel"}, 8'(bus.alu_sel), 8'(op));
        chk({tag, " rv_exec"}, 8'(bus.res_valid), 8'd0);
        @(negedge clk);
        chk({tag, " rv_wb"}, 8'(bus.res_valid), 8'd1);
        chk({tag, " res_data"}, bus.res_data, r);
        chk_flags({tag, " pre_wb"});
        @(negedge clk);
        chk({tag, " rv_done"}, 8'(bus.res_valid), 8'd0);
        chk({tag, " rdy_done"}, 8'(bus.instr_ready), 8'd1);
        m_regs[rd] = r;
        m_c = c;
        m_b = bw;
        m_z = (r == 8'h00);
        chk_flags(tag);
        chk_regs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int acc;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.dbg_addr    = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_c = 0; m_b = 0; m_z = 0;

        // reset state
        #12;
        chk("rst instr_ready", 8'(bus.instr_ready), 8'd1);
        chk("rst ld_ready", 8'(bus.ld_ready), 8'd1);
        chk("rst res_valid", 8'(bus.res_valid), 8'd0);
        chk("rst res_data", bus.res_data, 8'h00);
        chk("rst alu_a", bus.alu_a, 8'h00);
        chk("rst alu_sel", 8'(bus.alu_sel), 8'd0);
        chk_flags("rst");
        chk_regs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry
        do_load(2'd0, 8'hC8);
        do_load(2'd1, 8'h64);
        issue("add", OP_ADD, 2'd2, 2'd0, 2'd1, 0, 2'd0, 8'h00);
        chk("add r2", m_regs[2], 8'h2C);
        // SUB with borrow
        do_load(2'd0, 8'h05);
        do_load(2'd1, 8'h07);
        issue("sub", OP_SUB, 2'd3, 2'd0, 2'd1, 0, 2'd0, 8'h00);
        // AND to zero, then aliased OR
        do_load(2'd0, 8'hF0);
        do_load(2'd1, 8'h0F);
        issue("and", OP_AND, 2'd0, 2'd0, 2'd1, 0, 2'd0, 8'h00);
        issue("or", OP_OR, 2'd1, 2'd1, 2'd1, 0, 2'd0, 8'h00);

        // instr_valid held for 10 cycles: r1 = r1 + r1
        do_load(2'd1, 8'h01);
        @(negedge clk);
        bus.dbg_addr    = 2'd1;
        bus.instr       = {OP_ADD, 2'd1, 2'd1, 2'd1};
        bus.instr_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold ready c%0d", i), 8'(bus.instr_ready), 8'((i % 4) == 0));
            if (bus.instr_ready) acc++;
            if (i == 8) chk("hold r1 after 2", bus.dbg_data, 8'h04);
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hold accepts", 8'(acc), 8'd3);
        m_regs[1] = 8'h08; m_c = 0; m_b = 0; m_z = 0;
        chk_flags("hold");
        chk_regs("hold");

        // load and instruction in the same IDLE cycle
        issue("ld+add", OP_ADD, 2'd3, 2'd2, 2'd2, 1, 2'd2, 8'h10);
        chk("ld+add r3", m_regs[3], 8'h20);

        // randomized mix
        for (int n = 0; n < 30; n++) begin
            int k;
            k = $urandom_range(0, 2);
            if (k == 0)
                do_load(2'($urandom), 8'($urandom));
            else
                issue($sformatf("rnd%0d", n), 2'($urandom), 2'($urandom), 2'($urandom),
                      2'($urandom), (k == 2), 2'($urandom), 8'($urandom));
        end

        // reset during EXEC
        do_load(2'd0, 8'h80);
        do_load(2'd1, 8'h33);
        issue("pre_rst", OP_ADD, 2'd0, 2'd0, 2'd0, 0, 2'd0, 8'h00);
        @(negedge clk);
        bus.instr       = {OP_ADD, 2'd2, 2'd1, 2'd1};
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("exec alu_a", bus.alu_a, 8'h33);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_c = 0; m_b = 0; m_z = 0;
        chk("mid_rst res_valid", 8'(bus.res_valid), 8'd0);
        chk("mid_rst alu_a", bus.alu_a, 8'h00);
        chk("mid_rst ready", 8'(bus.instr_ready), 8'd1);
        chk_flags("mid_rst");
        chk_regs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst rv c%0d", i), 8'(bus.res_valid), 8'd0);
            chk($sformatf("post_rst rdy c%0d", i), 8'(bus.instr_ready), 8'd1);
        end
        chk_flags("post_rst");
        chk_regs("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
